rif_arbiter: RTL and testbench
==============================

RIF_ARBITER -- requirements
Module: rif_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of requesters (legal 2..4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, register address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width (8..1024, power of 2).
REQ-004 SHALL have parameter BYTE_COUNT, default DATA_WIDTH/8, strobe width.
REQ-005 Clocking: one clock; reset is asynchronous and active-low; ports are named HCLK and HRESETn.
REQ-006 HCLK  in  1  clock.
REQ-007 HRESETn  in  1  asynchronous active-low reset.
REQ-008 m_req  in  N_PORTS  per-port request; held until matching m_done.
REQ-009 m_write  in  N_PORTS  per-port direction: 1 = write, 0 = read.
REQ-010 m_addr  in  N_PORTS*ADDR_WIDTH  per-port address; port i at slice i.
REQ-011 m_wstrb  in  N_PORTS*BYTE_COUNT  per-port byte strobes.
REQ-012 m_wdata  in  N_PORTS*DATA_WIDTH  per-port write data.
REQ-013 m_done  out  N_PORTS  one-cycle completion pulse, one-hot or zero.
REQ-014 m_rdata  out  DATA_WIDTH  read data, valid while m_done is nonzero.
REQ-015 m_err  out  1  error flag, valid while m_done is nonzero.
REQ-016 rif_addr  out  ADDR_WIDTH  shared register-interface address.
REQ-017 rif_wr_req  out  1  write strobe.
REQ-018 rif_rd_req  out  1  read strobe.
REQ-019 rif_wstrb  out  BYTE_COUNT  write strobes.
REQ-020 rif_wdata  out  DATA_WIDTH  write data.
REQ-021 rif_addr_valid  in  1  address decodes to a register.
REQ-022 rif_rdata  in  DATA_WIDTH  read data, combinational from rif_addr.

Function
REQ-023 States: IDLE, ISSUE, RESP; state register resets to IDLE.
- IDLE: exit when m_req != 0.
- ISSUE: always one cycle.
- RESP: always one cycle, then back to IDLE.
REQ-024 On the IDLE→ISSUE clock edge, the block picks one winner and latches its addr, write, wstrb and wdata, plus the owner index.
REQ-025 In ISSUE, the block drives the rif_* outputs from the latched values:
- rif_wr_req = latched write;
- rif_rd_req = ~latched write;
- each strobe is high for exactly one cycle.
REQ-026 At the end of ISSUE, the block registers m_rdata = rif_rdata for reads and '0 for writes, and m_err = ~rif_addr_valid.
REQ-027 In RESP, m_done[owner] = 1; m_rdata and m_err hold the registered values.
REQ-028 Outside RESP: m_done = 0, m_err = 0, and m_rdata holds its last value.
REQ-029 Outside ISSUE: rif_wr_req and rif_rd_req = 0; rif_addr, rif_wstrb and rif_wdata hold their latched values.
REQ-030 Latency: request sampled in IDLE → m_done 2 cycles later; one access per 3 cycles at most.
REQ-031 Arbitration is round-robin:
- search starts at last_owner+1 mod N_PORTS;
- last_owner updates only on a grant.
REQ-032 The winner's payload is latched at grant; deasserting m_req after the grant does not abort the access, and m_done still pulses.
REQ-033 Requests arriving or changing during ISSUE or RESP are ignored until the next IDLE evaluation.
REQ-034 A port holding m_req after its m_done is treated as a new request.

Reset
REQ-035 Asynchronous reset values:
- state = IDLE, last_owner = N_PORTS-1 (port 0 wins first);
- all latched fields = '0;
- m_done = 0, m_rdata = '0, m_err = 0;
- rif_* outputs = '0.
REQ-036 Reset mid-access drops the access with no m_done; rif strobes deassert immediately.

Configuration
REQ-037 Macro RIF_ARB_FIXED_PRIO_EN:
- defined: fixed priority, lowest port index wins, and last_owner is not implemented;
- undefined: round-robin as in REQ-031.

Structure
REQ-038 Package rif_arb_pkg holds the state enum typedef (IDLE, ISSUE, RESP) and a function computing the owner index width from N_PORTS.
REQ-039 Sub-module rif_rr_picker holds the winner selection:
- inputs: request vector, last_owner;
- outputs: one-hot winner and its index;
- it also implements the fixed-priority variant under the macro.

Verification
REQ-040 Single read: port 0 reads addr 0x010, rif_rdata = 0xDEADBEEF, addr_valid = 1 → rif_rd_req pulses 1 cycle; 2 cycles later m_done = 01, m_rdata = 0xDEADBEEF, m_err = 0.
REQ-041 Contention: ports 0 and 1 request continuously from reset (write 0x004 and read 0x008) → grants alternate 0,1,0,1, with m_done spaced 3 cycles apart.
REQ-042 Error: port 1 writes addr 0xFFC with addr_valid = 0 → rif_wr_req pulses, m_done = 10, m_err = 1, m_rdata = 0.
REQ-043 Early drop: port 0 deasserts m_req the cycle after grant → the access still completes and m_done = 01.
REQ-044 Reset mid-access: HRESETn low during ISSUE → rif_wr_req = 0 at once, no m_done, first post-reset grant goes to port 0.
REQ-045 With RIF_ARB_FIXED_PRIO_EN defined, ports 0 and 1 requesting continuously → port 0 wins every grant.

Source files
------------

// File: rtl/rif_arb_pkg.sv
// Shared types and helpers for the register-interface arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rif_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } rif_state_t;

    // Width of an owner index for n requesters; never narrower than one bit.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rif_rr_picker.sv
// Winner selection among requesters: round-robin after i_last, or fixed
// lowest-index priority when RIF_ARB_FIXED_PRIO_EN is defined.
// Latency: combinational. Backpressure: none, a zero request gives a zero grant.
module rif_rr_picker
    import rif_arb_pkg::*;
#(
    parameter int N_PORTS = 2,
    parameter int IDX_W   = owner_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [N_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cidx;

    // Scan candidates in priority order and keep the first requester found.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cidx  = '0;
`ifdef RIF_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_PORTS; i++) begin
            w_cidx = IDX_W'(i);
            if (!w_found && i_req[w_cidx]) begin
                w_found         = 1'b1;
                o_grant[w_cidx] = 1'b1;
                o_idx           = w_cidx;
            end
        end
`else
        for (int k = 1; k <= N_PORTS; k++) begin
            w_cidx = IDX_W'((int'(i_last) + k) % N_PORTS);
            if (!w_found && i_req[w_cidx]) begin
                w_found         = 1'b1;
                o_grant[w_cidx] = 1'b1;
                o_idx           = w_cidx;
            end
        end
`endif
    end

endmodule

// File: rtl/rif_arbiter.sv
// N-port arbiter onto one register interface (IDLE -> ISSUE -> RESP).
// Latency: m_done two cycles after the request is sampled in IDLE; one access per 3 cycles.
// Backpressure: losers keep m_req high and wait; RIF_ARB_FIXED_PRIO_EN selects fixed priority.
module rif_arbiter
    import rif_arb_pkg::*;
#(
    parameter int N_PORTS    = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_COUNT = DATA_WIDTH / 8
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [N_PORTS-1:0]               m_req,
    input  logic [N_PORTS-1:0]               m_write,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]    m_addr,
    input  logic [N_PORTS*BYTE_COUNT-1:0]    m_wstrb,
    input  logic [N_PORTS*DATA_WIDTH-1:0]    m_wdata,
    output logic [N_PORTS-1:0]               m_done,
    output logic [DATA_WIDTH-1:0]            m_rdata,
    output logic                             m_err,
    output logic [ADDR_WIDTH-1:0]            rif_addr,
    output logic                             rif_wr_req,
    output logic                             rif_rd_req,
    output logic [BYTE_COUNT-1:0]            rif_wstrb,
    output logic [DATA_WIDTH-1:0]            rif_wdata,
    input  logic                             rif_addr_valid,
    input  logic [DATA_WIDTH-1:0]            rif_rdata
);

    localparam int IDX_W = owner_width(N_PORTS);

    rif_state_t            r_state;
    logic [IDX_W-1:0]      r_owner;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BYTE_COUNT-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [N_PORTS-1:0]    w_grant;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_last;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [BYTE_COUNT-1:0] w_sel_wstrb;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

`ifdef RIF_ARB_FIXED_PRIO_EN
    // Fixed priority has no history to keep.
    assign w_last = '0;
`else
    logic [IDX_W-1:0] r_last_owner;
    assign w_last = r_last_owner;

    // Remember the most recent grant; reset value makes port 0 win first.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_last_owner <= IDX_W'(N_PORTS - 1);
        end else if (r_state == IDLE && (|w_grant)) begin
            r_last_owner <= w_idx;
        end
    end
`endif

    rif_rr_picker #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (m_req),
        .i_last  (w_last),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // One-hot mux of the winning port's payload.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wstrb = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_grant[IDX_W'(i)]) begin
                w_sel_write = m_write[IDX_W'(i)];
                w_sel_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wstrb = m_wstrb[i*BYTE_COUNT +: BYTE_COUNT];
                w_sel_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The payload registers drive the interface directly so they hold between accesses.
    assign rif_addr  = r_addr;
    assign rif_wstrb = r_wstrb;
    assign rif_wdata = r_wdata;

    // Access sequencer: grant in IDLE, strobe in ISSUE, respond in RESP.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wstrb    <= '0;
            r_wdata    <= '0;
            rif_wr_req <= 1'b0;
            rif_rd_req <= 1'b0;
            m_done     <= '0;
            m_err      <= 1'b0;
            m_rdata    <= '0;
        end else begin
            rif_wr_req <= 1'b0;
            rif_rd_req <= 1'b0;
            m_done     <= '0;
            m_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_owner    <= w_idx;
                        r_write    <= w_sel_write;
                        r_addr     <= w_sel_addr;
                        r_wstrb    <= w_sel_wstrb;
                        r_wdata    <= w_sel_wdata;
                        rif_wr_req <= w_sel_write;
                        rif_rd_req <= ~w_sel_write;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // rif_rdata is combinational from rif_addr, so sample it here.
                    m_rdata <= r_write ? '0 : rif_rdata;
                    m_err   <= ~rif_addr_valid;
                    m_done  <= {{(N_PORTS-1){1'b0}}, 1'b1} << r_owner;
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rif_arbiter.sv
// Self-checking bench for rif_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level timing model.
// Define RIF_ARB_FIXED_PRIO_EN for both bench and RTL to test fixed priority.
module tb_rif_arbiter;

    localparam int N  = 2;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BC = DW / 8;
`ifdef RIF_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic [N-1:0]    m_req, m_write;
    logic [N*AW-1:0] m_addr;
    logic [N*BC-1:0] m_wstrb;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_done;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    logic [AW-1:0]   rif_addr;
    logic            rif_wr_req, rif_rd_req;
    logic [BC-1:0]   rif_wstrb;
    logic [DW-1:0]   rif_wdata;
    logic            rif_addr_valid;
    logic [DW-1:0]   rif_rdata;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    // Register-file model: fixed contents, top nibble 0xF is unmapped.
    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return {a, 8'hC3, a} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic vld_fn(input logic [AW-1:0] a);
        return a[11:8] != 4'hF;
    endfunction

    assign rif_rdata      = rd_fn(rif_addr);
    assign rif_addr_valid = vld_fn(rif_addr);

    rif_arbiter #(
        .N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_COUNT(BC)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m_req(m_req), .m_write(m_write), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
        .rif_addr(rif_addr), .rif_wr_req(rif_wr_req), .rif_rd_req(rif_rd_req),
        .rif_wstrb(rif_wstrb), .rif_wdata(rif_wdata),
        .rif_addr_valid(rif_addr_valid), .rif_rdata(rif_rdata)
    );

    task automatic set_port(input int i, input logic wr, input logic [AW-1:0] a,
                            input logic [BC-1:0] s, input logic [DW-1:0] d);
        m_write[i]         = wr;
        m_addr[i*AW +: AW] = a;
        m_wstrb[i*BC +: BC] = s;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic rand_port(input int i);
        logic [AW-1:0] a;
        a = AW'($urandom);
        if ($urandom_range(0, 5) == 0) a[11:8] = 4'hF;
        set_port(i, 1'($urandom), a, BC'($urandom), $urandom);
    endtask

    // Leaves the bench at a negedge with reset just released.
    task automatic do_reset;
        HRESETn = 1'b0;
        m_req   = '0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic go_idle;
        m_req = '0;
        repeat (3) @(negedge HCLK);
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        m_write = '0; m_addr = '0; m_wstrb = '0; m_wdata = '0;
        rand_port(0);
        rand_port(1);
        m_req = '1;
        repeat (2) @(negedge HCLK);
        checks++;
        if ({m_done, m_err, rif_wr_req, rif_rd_req} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0", {m_done, m_err, rif_wr_req, rif_rd_req});
        end
        checks++;
        if (m_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata got %h want 0", m_rdata);
        end
        checks++;
        if ({rif_addr, rif_wstrb, rif_wdata} !== '0) begin
            errors++; $display("FAIL reset_rif got %h want 0", {rif_addr, rif_wstrb, rif_wdata});
        end
        m_req   = '0;
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_single_read;
        go_idle();
        set_port(0, 1'b0, 12'h010, '0, '0);
        m_req = 2'b01;
        @(negedge HCLK);
        checks++;
        if ({rif_rd_req, rif_wr_req, rif_addr} !== {1'b1, 1'b0, 12'h010}) begin
            errors++;
            $display("FAIL read_issue got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=010",
                     rif_rd_req, rif_wr_req, rif_addr);
        end
        @(negedge HCLK);
        checks++;
        if ({m_done, m_err, rif_rd_req} !== {2'b01, 1'b0, 1'b0} || m_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_resp got done=%b err=%b rd=%b rdata=%h want 01 0 0 deadbeef",
                     m_done, m_err, rif_rd_req, m_rdata);
        end
        m_req = '0;
        @(negedge HCLK);
        checks++;
        if (m_done !== '0 || m_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_after got done=%b rdata=%h want 00 deadbeef", m_done, m_rdata);
        end
    endtask

    task automatic test_contention;
        logic [N-1:0] exp_done;
        do_reset();
        set_port(0, 1'b1, 12'h004, 4'hF, $urandom);
        set_port(1, 1'b0, 12'h008, '0, '0);
        m_req = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            @(negedge HCLK);
            if (k % 3 != 2)                  exp_done = 2'b00;
            else if (FIXED || (k / 3) % 2 == 0) exp_done = 2'b01;
            else                             exp_done = 2'b10;
            checks++;
            if (m_done !== exp_done) begin
                errors++;
                $display("FAIL contention_done cyc=%0d got %b want %b", k, m_done, exp_done);
            end
            if (exp_done != 2'b00) begin
                checks++;
                if (m_rdata !== (exp_done[1] ? rd_fn(12'h008) : '0)) begin
                    errors++;
                    $display("FAIL contention_rdata cyc=%0d got %h", k, m_rdata);
                end
            end
        end
        m_req = '0;
    endtask

    task automatic test_error;
        logic [DW-1:0] d;
        go_idle();
        d = $urandom;
        set_port(1, 1'b1, 12'hFFC, 4'hA, d);
        m_req = 2'b10;
        @(negedge HCLK);
        checks++;
        if ({rif_wr_req, rif_rd_req, rif_addr, rif_wstrb} !== {1'b1, 1'b0, 12'hFFC, 4'hA} ||
            rif_wdata !== d) begin
            errors++;
            $display("FAIL error_issue got wr=%b rd=%b addr=%h strb=%h data=%h want 1 0 ffc a %h",
                     rif_wr_req, rif_rd_req, rif_addr, rif_wstrb, rif_wdata, d);
        end
        @(negedge HCLK);
        checks++;
        if ({m_done, m_err} !== {2'b10, 1'b1} || m_rdata !== '0) begin
            errors++;
            $display("FAIL error_resp got done=%b err=%b rdata=%h want 10 1 0", m_done, m_err, m_rdata);
        end
        m_req = '0;
    endtask

    task automatic test_early_drop;
        go_idle();
        set_port(0, 1'b0, 12'h123, '0, '0);
        m_req = 2'b01;
        @(negedge HCLK);
        m_req = '0;
        @(negedge HCLK);
        checks++;
        if ({m_done, m_err} !== {2'b01, 1'b0} || m_rdata !== rd_fn(12'h123)) begin
            errors++;
            $display("FAIL early_drop got done=%b err=%b rdata=%h want 01 0 %h",
                     m_done, m_err, m_rdata, rd_fn(12'h123));
        end
    endtask

    task automatic test_reset_mid_access;
        go_idle();
        set_port(0, 1'b1, 12'h040, 4'h3, $urandom);
        m_req = 2'b01;
        @(negedge HCLK);
        checks++;
        if (rif_wr_req !== 1'b1) begin
            errors++; $display("FAIL midrst_issue got wr=%b want 1", rif_wr_req);
        end
        #1 HRESETn = 1'b0;
        #1;
        checks++;
        if (rif_wr_req !== 1'b0) begin
            errors++; $display("FAIL midrst_strobe got wr=%b want 0", rif_wr_req);
        end
        set_port(0, 1'b1, 12'h044, 4'h1, $urandom);
        set_port(1, 1'b1, 12'h080, 4'h2, $urandom);
        m_req = 2'b11;
        @(negedge HCLK);
        checks++;
        if (m_done !== '0) begin
            errors++; $display("FAIL midrst_nodone got %b want 00", m_done);
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
        checks++;
        if ({rif_wr_req, rif_addr} !== {1'b1, 12'h044} || m_done !== '0) begin
            errors++;
            $display("FAIL midrst_grant got wr=%b addr=%h done=%b want 1 044 00",
                     rif_wr_req, rif_addr, m_done);
        end
        m_req = '0;
        @(negedge HCLK);
        checks++;
        if (m_done !== 2'b01) begin
            errors++; $display("FAIL midrst_done got %b want 01", m_done);
        end
    endtask

    // Model: a grant at decision cycle t strobes at t+1, completes at t+2,
    // and the next decision is allowed at t+3.
    task automatic test_random;
        int            cyc, next_free, g_cyc, g_port, last_own, c;
        bit            have_g, exp_issue, exp_resp;
        logic          g_write;
        logic [AW-1:0] lat_addr;
        logic [BC-1:0] lat_wstrb;
        logic [DW-1:0] lat_wdata, last_rd;
        logic [N-1:0]  exp_done;
        logic          exp_err;
        do_reset();
        cyc = 0; next_free = 0; g_cyc = 0; g_port = 0; last_own = N - 1;
        have_g = 1'b0; g_write = 1'b0;
        lat_addr = '0; lat_wstrb = '0; lat_wdata = '0; last_rd = '0;
        for (int n = 0; n < 1500; n++) begin
            exp_issue = have_g && (cyc == g_cyc + 1);
            exp_resp  = have_g && (cyc == g_cyc + 2);
            checks++;
            if (rif_wr_req !== (exp_issue && g_write) || rif_rd_req !== (exp_issue && !g_write)) begin
                errors++;
                $display("FAIL rand_strobe cyc=%0d got wr=%b rd=%b want wr=%b rd=%b", cyc,
                         rif_wr_req, rif_rd_req, exp_issue && g_write, exp_issue && !g_write);
            end
            checks++;
            if ({rif_addr, rif_wstrb, rif_wdata} !== {lat_addr, lat_wstrb, lat_wdata}) begin
                errors++;
                $display("FAIL rand_payload cyc=%0d got %h/%h/%h want %h/%h/%h", cyc,
                         rif_addr, rif_wstrb, rif_wdata, lat_addr, lat_wstrb, lat_wdata);
            end
            exp_done = exp_resp ? (N'(1) << g_port) : '0;
            exp_err  = exp_resp && !vld_fn(lat_addr);
            if (exp_resp) last_rd = g_write ? '0 : rd_fn(lat_addr);
            checks++;
            if (m_done !== exp_done || m_err !== exp_err || m_rdata !== last_rd) begin
                errors++;
                $display("FAIL rand_resp cyc=%0d got done=%b err=%b rdata=%h want %b %b %h", cyc,
                         m_done, m_err, m_rdata, exp_done, exp_err, last_rd);
            end
            for (int i = 0; i < N; i++) begin
                if (m_req[i]) begin
                    if (exp_done[i]) begin
                        if ($urandom_range(0, 1) == 0) m_req[i] = 1'b0;
                        else rand_port(i);
                    end else if ($urandom_range(0, 15) == 0) begin
                        m_req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    rand_port(i);
                    m_req[i] = 1'b1;
                end
            end
            if (cyc >= next_free && m_req != '0) begin
                g_port = -1;
                for (int k = 1; k <= N; k++) begin
                    c = FIXED ? (k - 1) : ((last_own + k) % N);
                    if (g_port < 0 && m_req[c]) g_port = c;
                end
                have_g    = 1'b1;
                g_cyc     = cyc;
                next_free = cyc + 3;
                last_own  = g_port;
                g_write   = m_write[g_port];
                lat_addr  = m_addr[g_port*AW +: AW];
                lat_wstrb = m_wstrb[g_port*BC +: BC];
                lat_wdata = m_wdata[g_port*DW +: DW];
            end
            @(negedge HCLK);
            cyc++;
        end
        m_req = '0;
    endtask

    initial begin
        HRESETn = 1'b0;
        m_req = '0; m_write = '0; m_addr = '0; m_wstrb = '0; m_wdata = '0;
        @(negedge HCLK);
        test_reset();
        test_single_read();
        test_contention();
        test_error();
        test_early_drop();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
